cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum cycles to wait for mem_ready before faulting, range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 Port clk: input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 Port reset: input, 1 bit; synchronous, active-low; 0 = reset.
REQ-005 Inputs opcode[2:0], op[1:0], cond[2:0]: decoded fields from the instruction register.
REQ-006 Inputs Z, N, V, 1 bit each: registered status flags.
REQ-007 Input mem_ready, 1 bit: memory has completed the current MREAD/MWRITE.
REQ-008 Outputs asel, bsel, loada, loadb, loadc, loads, write_regfile, 1 bit each: datapath controls with the existing meanings.
REQ-009 Outputs vsel[1:0] and nsel[2:0] (one-hot: 001 Rn, 010 Rd, 100 Rm): datapath controls.
REQ-010 Outputs load_pc, reset_pc, pc_sel, load_addr, addr_sel, load_ir, 1 bit each: program-counter, address and IR controls; pc_sel=1 selects the branch target, 0 selects PC+1.
REQ-011 Output mem_cmd[1:0]: memory command; 00 NONE, 01 READ, 10 WRITE.
REQ-012 Outputs halted and fault, 1 bit each, and retired[CNT_W-1:0]: status outputs.

Function
REQ-013 States: RST, IF1, IF2, UPC, DEC, GETA, GETB, EXEC, STORE, ADDR, MRD, EXSTR, MWR, BR, HALT, FAULT.
REQ-014 Fetch path is RST->IF1. IF1 holds addr_sel=1 and mem_cmd=READ until mem_ready=1, then goes to IF2.
REQ-015 IF2 asserts load_ir=1 with mem_cmd=READ, then goes to UPC.
REQ-016 UPC asserts load_pc=1 with pc_sel=0, then goes to DEC.
REQ-017 DEC dispatch on {opcode,op}:
 - 11010 -> STORE
 - 11000 or 10111 -> GETB
 - 10100, 10101, 10110, 01100, 10000 -> GETA
 - opcode 111 -> HALT
 - opcode 001 -> BR
 - anything else -> RST
REQ-018 Datapath sequencing, control values and STR/LDR address flow are identical to the previous-generation controller. The LDR read state MRD and the write state MWR each hold mem_cmd until mem_ready=1.
REQ-019 In BR, taken is evaluated as follows:
 - cond 000: always
 - cond 001: Z
 - cond 010: !Z
 - cond 011: N!=V
 - cond 100: (N!=V)|Z
 - other codes: never
REQ-020 When the branch is taken, BR asserts load_pc=1 with pc_sel=1 for exactly one cycle. When it is not taken, no PC load occurs. BR then goes to IF1.
REQ-021 A wait counter clears on entry to IF1, MRD or MWR. It increments each cycle mem_ready=0. On reaching MEM_TIMEOUT it moves to FAULT.
REQ-022 mem_ready is sampled only in IF1, MRD and MWR; it is ignored in all other states.
REQ-023 retired increments by 1 on each transition into IF1 from STORE, EXEC (CMP), MWR or BR. It wraps from all-ones to 0.
REQ-024 HALT and FAULT are absorbing states that only reset exits. Their outputs are:
 - all control outputs 0, mem_cmd=NONE
 - HALT: halted=1
 - FAULT: fault=1
REQ-025 Outputs are a combinational function of state, {opcode,op} and cond. Unlisted controls are 0.
REQ-026 An illegal state encoding goes to RST.

Reset
REQ-027 When reset=0 at a clock edge, the controller enters RST regardless of state, including mid-wait in IF1, MRD or MWR. It also clears the wait counter, retired, halted and fault.
REQ-028 RST outputs load_pc=1 and reset_pc=1; all other outputs are 0.
REQ-029 The first cycle after reset returns to 1 is RST, followed by IF1.

Structure
REQ-030 A shared package cpu_ctrl_pkg holds:
 - state encodings
 - mem_cmd codes MNONE, MREAD, MWRITE
 - {opcode,op} instruction constants
 - cond codes
REQ-031 One sub-module, mem_wait_timer, holds the wait counter and its timeout compare.

Verification
REQ-032 Reset, then mem_ready=1 constantly with MOV R0,#5 -> observe RST,IF1,IF2,UPC,DEC,STORE,IF1; vsel=10 and nsel=001 in STORE; retired=1.
REQ-033 LDR with mem_ready delayed 3 cycles in MRD -> MRD lasts 4 cycles; STORE shows vsel=11; fault=0.
REQ-034 MEM_TIMEOUT=4 with mem_ready held 0 in IF1 -> FAULT after 4 wait cycles; fault=1 held until reset=0.
REQ-035 Branch checks:
 - cond=001, Z=1: load_pc=1 and pc_sel=1 for one cycle in BR
 - cond=001, Z=0: no load_pc in BR
 - either case: retired increments
REQ-036 opcode 111 -> HALT with halted=1 for 20 cycles. Then reset=0 for one edge -> RST with reset_pc=1, halted=0, retired=0.
REQ-037 Set CNT_W=2 and run 5 instructions -> retired sequence 1,2,3,0,1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU control FSM: states, memory commands,
// instruction {opcode,op} constants, branch condition codes and datapath selects.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_IF1   = 4'd1,
        S_IF2   = 4'd2,
        S_UPC   = 4'd3,
        S_DEC   = 4'd4,
        S_GETA  = 4'd5,
        S_GETB  = 4'd6,
        S_EXEC  = 4'd7,
        S_STORE = 4'd8,
        S_ADDR  = 4'd9,
        S_MRD   = 4'd10,
        S_EXSTR = 4'd11,
        S_MWR   = 4'd12,
        S_BR    = 4'd13,
        S_HALT  = 4'd14,
        S_FAULT = 4'd15
    } state_t;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [4:0] I_MOVI = 5'b11010;
    localparam logic [4:0] I_MOV  = 5'b11000;
    localparam logic [4:0] I_MVN  = 5'b10111;
    localparam logic [4:0] I_ADD  = 5'b10100;
    localparam logic [4:0] I_CMP  = 5'b10101;
    localparam logic [4:0] I_AND  = 5'b10110;
    localparam logic [4:0] I_LDR  = 5'b01100;
    localparam logic [4:0] I_STR  = 5'b10000;

    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [2:0] C_AL = 3'b000;
    localparam logic [2:0] C_EQ = 3'b001;
    localparam logic [2:0] C_NE = 3'b010;
    localparam logic [2:0] C_LT = 3'b011;
    localparam logic [2:0] C_LE = 3'b100;

    localparam logic [2:0] NS_RN = 3'b001;
    localparam logic [2:0] NS_RD = 3'b010;
    localparam logic [2:0] NS_RM = 3'b100;

    localparam logic [1:0] VS_C     = 2'b00;
    localparam logic [1:0] VS_IMM   = 2'b10;
    localparam logic [1:0] VS_MDATA = 2'b11;

    function automatic logic branch_taken(input logic [2:0] c, input logic z,
                                          input logic n, input logic v);
        case (c)
            C_AL:    return 1'b1;
            C_EQ:    return z;
            C_NE:    return !z;
            C_LT:    return n ^ v;
            C_LE:    return (n ^ v) | z;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags expiry on the cycle whose
// increment would reach TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc)
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_expire = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU controller: fetch/decode/execute sequencing with memory
// handshake, wait timeout, branch evaluation and a retired-instruction counter.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    input  logic [2:0]       cond,
    input  logic             Z,
    input  logic             N,
    input  logic             V,
    input  logic             mem_ready,
    output logic             asel,
    output logic             bsel,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             write_regfile,
    output logic [1:0]       vsel,
    output logic [2:0]       nsel,
    output logic             load_pc,
    output logic             reset_pc,
    output logic             pc_sel,
    output logic             load_addr,
    output logic             addr_sel,
    output logic             load_ir,
    output logic [1:0]       mem_cmd,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);
    state_t           r_state;
    state_t           w_next;
    logic [4:0]       w_instr;
    logic             w_waiting;
    logic             w_inc;
    logic             w_clr;
    logic             w_expire;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    assign w_instr   = {opcode, op};
    assign w_waiting = r_state inside {S_IF1, S_MRD, S_MWR};
    assign w_inc     = w_waiting && !mem_ready;
    assign w_clr     = (w_next != r_state);
    assign w_retire  = (w_next == S_IF1) && (r_state inside {S_STORE, S_EXEC, S_MWR, S_BR});
    assign retired   = r_retired;

    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = r_state;
        asel          = 1'b0;
        bsel          = 1'b0;
        loada         = 1'b0;
        loadb         = 1'b0;
        loadc         = 1'b0;
        loads         = 1'b0;
        write_regfile = 1'b0;
        vsel          = VS_C;
        nsel          = 3'b000;
        load_pc       = 1'b0;
        reset_pc      = 1'b0;
        pc_sel        = 1'b0;
        load_addr     = 1'b0;
        addr_sel      = 1'b0;
        load_ir       = 1'b0;
        mem_cmd       = MNONE;
        halted        = 1'b0;
        fault         = 1'b0;

        case (r_state)
            S_RST: begin
                load_pc  = 1'b1;
                reset_pc = 1'b1;
                w_next   = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
                if (mem_ready)     w_next = S_IF2;
                else if (w_expire) w_next = S_FAULT;
            end
            S_IF2: begin
                // PC still drives the address while the IR captures the word
                addr_sel = 1'b1;
                load_ir  = 1'b1;
                mem_cmd  = MREAD;
                w_next   = S_UPC;
            end
            S_UPC: begin
                load_pc = 1'b1;
                w_next  = S_DEC;
            end
            S_DEC: begin
                if (w_instr == I_MOVI)
                    w_next = S_STORE;
                else if (w_instr == I_MOV || w_instr == I_MVN)
                    w_next = S_GETB;
                else if (w_instr inside {I_ADD, I_CMP, I_AND, I_LDR, I_STR})
                    w_next = S_GETA;
                else if (opcode == OPC_HALT)
                    w_next = S_HALT;
                else if (opcode == OPC_BR)
                    w_next = S_BR;
                else
                    w_next = S_RST;
            end
            S_GETA: begin
                nsel   = NS_RN;
                loada  = 1'b1;
                w_next = (w_instr == I_LDR || w_instr == I_STR) ? S_EXEC : S_GETB;
            end
            S_GETB: begin
                nsel   = NS_RM;
                loadb  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                if (w_instr == I_LDR || w_instr == I_STR) begin
                    bsel   = 1'b1;
                    loadc  = 1'b1;
                    w_next = S_ADDR;
                end else if (w_instr == I_CMP) begin
                    loads  = 1'b1;
                    w_next = S_IF1;
                end else if (w_instr == I_MOV || w_instr == I_MVN) begin
                    asel   = 1'b1;
                    loadc  = 1'b1;
                    w_next = S_STORE;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_STORE;
                end
            end
            S_STORE: begin
                write_regfile = 1'b1;
                if (w_instr == I_MOVI) begin
                    vsel = VS_IMM;
                    nsel = NS_RN;
                end else if (w_instr == I_LDR) begin
                    vsel = VS_MDATA;
                    nsel = NS_RD;
                end else begin
                    vsel = VS_C;
                    nsel = NS_RD;
                end
                w_next = S_IF1;
            end
            S_ADDR: begin
                load_addr = 1'b1;
                if (w_instr == I_STR) begin
                    // fetch the store data into B while the address is latched
                    nsel   = NS_RD;
                    loadb  = 1'b1;
                    w_next = S_EXSTR;
                end else begin
                    w_next = S_MRD;
                end
            end
            S_MRD: begin
                mem_cmd = MREAD;
                if (mem_ready)     w_next = S_STORE;
                else if (w_expire) w_next = S_FAULT;
            end
            S_EXSTR: begin
                asel   = 1'b1;
                loadc  = 1'b1;
                w_next = S_MWR;
            end
            S_MWR: begin
                mem_cmd = MWRITE;
                if (mem_ready)     w_next = S_IF1;
                else if (w_expire) w_next = S_FAULT;
            end
            S_BR: begin
                if (branch_taken(cond, Z, N, V)) begin
                    load_pc = 1'b1;
                    pc_sel  = 1'b1;
                end
                w_next = S_IF1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a default instance plus a small one
// (MEM_TIMEOUT=4, CNT_W=2) driven by the same stimulus.
module tb_cpu_control_fsm;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [2:0] cond = 3'b000;
    logic       Z = 1'b0, N = 1'b0, V = 1'b0;
    logic       mem_ready = 1'b0;

    logic        asel, bsel, loada, loadb, loadc, loads, write_regfile;
    logic [1:0]  vsel, mem_cmd;
    logic [2:0]  nsel;
    logic        load_pc, reset_pc, pc_sel, load_addr, addr_sel, load_ir, halted, fault;
    logic [15:0] retired;

    logic        s_asel, s_bsel, s_loada, s_loadb, s_loadc, s_loads, s_write_regfile;
    logic [1:0]  s_vsel, s_mem_cmd;
    logic [2:0]  s_nsel;
    logic        s_load_pc, s_reset_pc, s_pc_sel, s_load_addr, s_addr_sel, s_load_ir;
    logic        s_halted, s_fault;
    logic [1:0]  s_retired;

    int n_vec = 0;
    int n_bad = 0;
    int exp_ret = 0;
    logic [1:0] wrap_exp [5];
    logic [6:0] br_tab [8];

    cpu_control_fsm u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .Z(Z), .N(N), .V(V), .mem_ready(mem_ready),
        .asel(asel), .bsel(bsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .write_regfile(write_regfile), .vsel(vsel), .nsel(nsel),
        .load_pc(load_pc), .reset_pc(reset_pc), .pc_sel(pc_sel), .load_addr(load_addr),
        .addr_sel(addr_sel), .load_ir(load_ir), .mem_cmd(mem_cmd),
        .halted(halted), .fault(fault), .retired(retired)
    );

    cpu_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .Z(Z), .N(N), .V(V), .mem_ready(mem_ready),
        .asel(s_asel), .bsel(s_bsel), .loada(s_loada), .loadb(s_loadb), .loadc(s_loadc),
        .loads(s_loads), .write_regfile(s_write_regfile), .vsel(s_vsel), .nsel(s_nsel),
        .load_pc(s_load_pc), .reset_pc(s_reset_pc), .pc_sel(s_pc_sel),
        .load_addr(s_load_addr), .addr_sel(s_addr_sel), .load_ir(s_load_ir),
        .mem_cmd(s_mem_cmd), .halted(s_halted), .fault(s_fault), .retired(s_retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_ret = 0;
    endtask

    // IF1 -> IF2 -> UPC -> DEC with mem_ready already high
    task automatic fetch();
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        opcode = 3'b110; op = 2'b10; mem_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_RST) begin
            n_bad++; $display("FAIL reset_state got %0d want %0d", u_dut.r_state, S_RST);
        end
        n_vec++;
        if ({load_pc, reset_pc, mem_cmd, write_regfile, load_ir} !== 6'b110000) begin
            n_bad++; $display("FAIL reset_outputs got %b want 110000",
                              {load_pc, reset_pc, mem_cmd, write_regfile, load_ir});
        end
        n_vec++;
        if ({retired, s_retired, halted, fault} !== 20'd0) begin
            n_bad++; $display("FAIL reset_status got ret=%0d sret=%0d h=%b f=%b want 0",
                              retired, s_retired, halted, fault);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (u_dut.r_state !== S_RST) begin
            n_bad++; $display("FAIL reset_release_rst got %0d want %0d", u_dut.r_state, S_RST);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_IF1) begin
            n_bad++; $display("FAIL reset_then_if1 got %0d want %0d", u_dut.r_state, S_IF1);
        end
    endtask

    task automatic test_mov_imm();
        do_reset();
        mem_ready = 1'b1;
        {opcode, op} = I_MOVI;
        tick();
        n_vec++;
        if (u_dut.r_state !== S_IF1 || {addr_sel, mem_cmd} !== 3'b101) begin
            n_bad++; $display("FAIL mov_if1 got st=%0d as/cmd=%b want st=%0d 101",
                              u_dut.r_state, {addr_sel, mem_cmd}, S_IF1);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_IF2 || {load_ir, mem_cmd} !== 3'b101) begin
            n_bad++; $display("FAIL mov_if2 got st=%0d ir/cmd=%b want st=%0d 101",
                              u_dut.r_state, {load_ir, mem_cmd}, S_IF2);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_UPC || {load_pc, pc_sel} !== 2'b10) begin
            n_bad++; $display("FAIL mov_upc got st=%0d pc=%b want st=%0d 10",
                              u_dut.r_state, {load_pc, pc_sel}, S_UPC);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_DEC) begin
            n_bad++; $display("FAIL mov_dec got %0d want %0d", u_dut.r_state, S_DEC);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_STORE || {vsel, nsel, write_regfile} !== 6'b10_001_1) begin
            n_bad++; $display("FAIL mov_store got st=%0d v/n/w=%b want st=%0d 100011",
                              u_dut.r_state, {vsel, nsel, write_regfile}, S_STORE);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_IF1 || retired !== 16'd1 || s_retired !== 2'd1) begin
            n_bad++; $display("FAIL mov_retire got st=%0d ret=%0d sret=%0d want st=%0d 1 1",
                              u_dut.r_state, retired, s_retired, S_IF1);
        end
    endtask

    task automatic test_alu();
        do_reset();
        mem_ready = 1'b1;
        tick();
        {opcode, op} = I_ADD;
        fetch();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_GETA || {nsel, loada} !== 4'b0011) begin
            n_bad++; $display("FAIL add_geta got st=%0d n/la=%b want st=%0d 0011",
                              u_dut.r_state, {nsel, loada}, S_GETA);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_GETB || {nsel, loadb} !== 4'b1001) begin
            n_bad++; $display("FAIL add_getb got st=%0d n/lb=%b want st=%0d 1001",
                              u_dut.r_state, {nsel, loadb}, S_GETB);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_EXEC || {asel, bsel, loadc, loads} !== 4'b0010) begin
            n_bad++; $display("FAIL add_exec got st=%0d ctl=%b want st=%0d 0010",
                              u_dut.r_state, {asel, bsel, loadc, loads}, S_EXEC);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_STORE || {vsel, nsel, write_regfile} !== 6'b00_010_1) begin
            n_bad++; $display("FAIL add_store got st=%0d v/n/w=%b want st=%0d 000101",
                              u_dut.r_state, {vsel, nsel, write_regfile}, S_STORE);
        end
        tick();
        exp_ret++;
        {opcode, op} = I_CMP;
        fetch();
        tick();
        tick();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_EXEC || {asel, bsel, loadc, loads} !== 4'b0001) begin
            n_bad++; $display("FAIL cmp_exec got st=%0d ctl=%b want st=%0d 0001",
                              u_dut.r_state, {asel, bsel, loadc, loads}, S_EXEC);
        end
        tick();
        exp_ret++;
        n_vec++;
        if (u_dut.r_state !== S_IF1 || retired !== 16'(exp_ret)) begin
            n_bad++; $display("FAIL cmp_retire got st=%0d ret=%0d want st=%0d ret=%0d",
                              u_dut.r_state, retired, S_IF1, exp_ret);
        end
        {opcode, op} = 5'b01000;
        fetch();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_RST || retired !== 16'(exp_ret)) begin
            n_bad++; $display("FAIL illegal_dispatch got st=%0d ret=%0d want st=%0d ret=%0d",
                              u_dut.r_state, retired, S_RST, exp_ret);
        end
        tick();
        {opcode, op} = I_MVN;
        fetch();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_GETB) begin
            n_bad++; $display("FAIL mvn_getb got %0d want %0d", u_dut.r_state, S_GETB);
        end
        tick();
        n_vec++;
        if ({asel, bsel, loadc, loads} !== 4'b1010) begin
            n_bad++; $display("FAIL mvn_exec got %b want 1010", {asel, bsel, loadc, loads});
        end
        tick();
        tick();
        exp_ret++;
        n_vec++;
        if (u_dut.r_state !== S_IF1 || retired !== 16'(exp_ret)) begin
            n_bad++; $display("FAIL mvn_retire got st=%0d ret=%0d want st=%0d ret=%0d",
                              u_dut.r_state, retired, S_IF1, exp_ret);
        end
    endtask

    task automatic test_ldr_str();
        do_reset();
        mem_ready = 1'b1;
        tick();
        {opcode, op} = I_LDR;
        fetch();
        tick();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_EXEC || {asel, bsel, loadc, loads} !== 4'b0110) begin
            n_bad++; $display("FAIL ldr_exec got st=%0d ctl=%b want st=%0d 0110",
                              u_dut.r_state, {asel, bsel, loadc, loads}, S_EXEC);
        end
        tick();
        mem_ready = 1'b0;
        n_vec++;
        if (u_dut.r_state !== S_ADDR || load_addr !== 1'b1) begin
            n_bad++; $display("FAIL ldr_addr got st=%0d la=%b want st=%0d 1",
                              u_dut.r_state, load_addr, S_ADDR);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_MRD || {mem_cmd, addr_sel} !== 3'b010) begin
            n_bad++; $display("FAIL ldr_mrd1 got st=%0d cmd/as=%b want st=%0d 010",
                              u_dut.r_state, {mem_cmd, addr_sel}, S_MRD);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_vec++;
            if (u_dut.r_state !== S_MRD || u_small.r_state !== S_MRD) begin
                n_bad++; $display("FAIL ldr_mrd_hold cyc=%0d got %0d/%0d want %0d",
                                  i, u_dut.r_state, u_small.r_state, S_MRD);
            end
        end
        mem_ready = 1'b1;
        tick();
        n_vec++;
        if (u_dut.r_state !== S_STORE || {vsel, nsel, write_regfile} !== 6'b11_010_1) begin
            n_bad++; $display("FAIL ldr_store got st=%0d v/n/w=%b want st=%0d 110101",
                              u_dut.r_state, {vsel, nsel, write_regfile}, S_STORE);
        end
        n_vec++;
        if (fault !== 1'b0 || s_fault !== 1'b0 || u_small.r_state !== S_STORE) begin
            n_bad++; $display("FAIL ldr_no_fault got f=%b sf=%b sst=%0d want 0 0 %0d",
                              fault, s_fault, u_small.r_state, S_STORE);
        end
        tick();
        exp_ret++;
        {opcode, op} = I_STR;
        fetch();
        tick();
        tick();
        tick();
        n_vec++;
        if (u_dut.r_state !== S_ADDR || {load_addr, loadb, nsel} !== 5'b11010) begin
            n_bad++; $display("FAIL str_addr got st=%0d ctl=%b want st=%0d 11010",
                              u_dut.r_state, {load_addr, loadb, nsel}, S_ADDR);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_EXSTR || {asel, loadc} !== 2'b11) begin
            n_bad++; $display("FAIL str_exstr got st=%0d ctl=%b want st=%0d 11",
                              u_dut.r_state, {asel, loadc}, S_EXSTR);
        end
        tick();
        n_vec++;
        if (u_dut.r_state !== S_MWR || mem_cmd !== MWRITE) begin
            n_bad++; $display("FAIL str_mwr got st=%0d cmd=%b want st=%0d 10",
                              u_dut.r_state, mem_cmd, S_MWR);
        end
        tick();
        exp_ret++;
        n_vec++;
        if (u_dut.r_state !== S_IF1 || retired !== 16'(exp_ret)) begin
            n_bad++; $display("FAIL str_retire got st=%0d ret=%0d want st=%0d ret=%0d",
                              u_dut.r_state, retired, S_IF1, exp_ret);
        end
    endtask

    task automatic test_branch();
        // {cond, Z, N, V, taken}
        br_tab[0] = {3'b001, 1'b1, 1'b0, 1'b0, 1'b1};
        br_tab[1] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
        br_tab[2] = {3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
        br_tab[3] = {3'b011, 1'b0, 1'b1, 1'b0, 1'b1};
        br_tab[4] = {3'b100, 1'b0, 1'b1, 1'b1, 1'b0};
        br_tab[5] = {3'b100, 1'b1, 1'b1, 1'b1, 1'b1};
        br_tab[6] = {3'b101, 1'b1, 1'b0, 1'b1, 1'b0};
        br_tab[7] = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        mem_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            {opcode, op} = {OPC_BR, 2'b00};
            {cond, Z, N, V} = br_tab[i][6:1];
            fetch();
            tick();
            n_vec++;
            if (u_dut.r_state !== S_BR || {load_pc, pc_sel} !== {2{br_tab[i][0]}}) begin
                n_bad++; $display("FAIL branch_%0d got st=%0d pc=%b want st=%0d %b%b",
                                  i, u_dut.r_state, {load_pc, pc_sel}, S_BR,
                                  br_tab[i][0], br_tab[i][0]);
            end
            tick();
            exp_ret++;
            n_vec++;
            if (u_dut.r_state !== S_IF1 || load_pc !== 1'b0 || retired !== 16'(exp_ret)
                || s_retired !== 2'(exp_ret)) begin
                n_bad++; $display("FAIL branch_retire_%0d got st=%0d lpc=%b ret=%0d sret=%0d want ret=%0d",
                                  i, u_dut.r_state, load_pc, retired, s_retired, exp_ret);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_ready = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_vec++;
            if (u_small.r_state !== (k >= 4 ? S_FAULT : S_IF1) || s_fault !== (k >= 4)) begin
                n_bad++; $display("FAIL timeout_small k=%0d got st=%0d f=%b", k,
                                  u_small.r_state, s_fault);
            end
            n_vec++;
            if (u_dut.r_state !== (k >= 16 ? S_FAULT : S_IF1) || fault !== (k >= 16)) begin
                n_bad++; $display("FAIL timeout_default k=%0d got st=%0d f=%b", k,
                                  u_dut.r_state, fault);
            end
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_vec++;
            if ({s_fault, s_halted, s_load_pc, s_mem_cmd, s_addr_sel} !== 6'b100000) begin
                n_bad++; $display("FAIL fault_hold k=%0d got %b want 100000", k,
                                  {s_fault, s_halted, s_load_pc, s_mem_cmd, s_addr_sel});
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (fault !== 1'b0 || s_fault !== 1'b0 || u_small.r_state !== S_RST) begin
            n_bad++; $display("FAIL fault_reset got f=%b sf=%b sst=%0d want 0 0 %0d",
                              fault, s_fault, u_small.r_state, S_RST);
        end
        reset = 1'b1;
    endtask

    task automatic test_halt();
        do_reset();
        mem_ready = 1'b1;
        tick();
        {opcode, op} = I_MOVI;
        fetch();
        tick();
        tick();
        {opcode, op} = {OPC_HALT, 2'b00};
        fetch();
        tick();
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            n_vec++;
            if (u_dut.r_state !== S_HALT
                || {halted, fault, load_pc, mem_cmd, write_regfile, load_ir} !== 7'b1000000) begin
                n_bad++; $display("FAIL halt_hold k=%0d got st=%0d out=%b want 1000000", k,
                                  u_dut.r_state, {halted, fault, load_pc, mem_cmd, write_regfile, load_ir});
            end
            tick();
        end
        n_vec++;
        if (retired !== 16'd1) begin
            n_bad++; $display("FAIL halt_retired got %0d want 1", retired);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_vec++;
        if (u_dut.r_state !== S_RST || {reset_pc, load_pc, halted} !== 3'b110
            || retired !== 16'd0) begin
            n_bad++; $display("FAIL halt_reset got st=%0d rpc/lpc/h=%b ret=%0d want st=%0d 110 0",
                              u_dut.r_state, {reset_pc, load_pc, halted}, retired, S_RST);
        end
    endtask

    task automatic test_back_to_back();
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
        do_reset();
        mem_ready = 1'b1;
        tick();
        {opcode, op} = I_MOVI;
        for (int i = 0; i < 5; i++) begin
            fetch();
            tick();
            tick();
            n_vec++;
            if (s_retired !== wrap_exp[i] || retired !== 16'(i + 1)) begin
                n_bad++; $display("FAIL wrap_%0d got sret=%0d ret=%0d want %0d %0d",
                                  i, s_retired, retired, wrap_exp[i], i + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_alu();
        test_ldr_str();
        test_branch();
        test_timeout();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
